// File: rtl/booth_pp_accumulator.sv
// Purpose: sequential reducer summing six pre-shifted radix-8 Booth partial products into a 32-bit signed product.
// Latency: 6 cycles from accept to out_valid; minimum 8-cycle transaction period (one bubble after each consume).
// Backpressure: in_ready only in IDLE; product/ovf held stable in DONE until out_ready.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready + pp0..pp5 (PP_W signed) input handshake;
//        out_valid/out_ready + product (PROD_W signed) + ovf output handshake.
// Optional feature: define BOOTH_ACC_OVF_CHECK_EN to flag results that do not fit PROD_W signed bits;
//        otherwise ovf is tied to 0 and no check logic exists.
module booth_pp_accumulator #(
  parameter int NUM_PP = 6,
  parameter int PP_W   = 34,
  parameter int PROD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PP_W-1:0]   pp0,
  input  logic signed [PP_W-1:0]   pp1,
  input  logic signed [PP_W-1:0]   pp2,
  input  logic signed [PP_W-1:0]   pp3,
  input  logic signed [PP_W-1:0]   pp4,
  input  logic signed [PP_W-1:0]   pp5,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [PROD_W-1:0] product,
  output logic                     ovf
);

  localparam int CNT_W = $clog2(NUM_PP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PP_W-1:0]  pp_q [NUM_PP];
  logic [PP_W-1:0]  pp_d [NUM_PP];
  logic [PP_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PP_W-1:0]  pp_sel;
  logic [PP_W-1:0]  acc_sum;
  logic             last_add;
  logic             accept;

  // Explicit select mux: cnt is wider than needed to index NUM_PP entries,
  // so out-of-range codes fall back to zero instead of an undefined read.
  always_comb begin
    pp_sel = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      if (cnt_q == CNT_W'(i)) pp_sel = pp_q[i];
    end
  end

  // Two's-complement add wraps naturally at PP_W bits.
  assign acc_sum  = acc_q + pp_sel;
  assign last_add = (cnt_q == CNT_W'(NUM_PP - 1));
  assign accept   = (state_q == IDLE) && in_valid;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    pp_d      = pp_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pp_d[0] = pp0;
          pp_d[1] = pp1;
          pp_d[2] = pp2;
          pp_d[3] = pp3;
          pp_d[4] = pp4;
          pp_d[5] = pp5;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_sum;
        if (last_add) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Consume returns to IDLE; a simultaneous in_valid waits for the IDLE cycle.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_PP; i++) pp_q[i] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pp_q    <= pp_d;
    end
  end

  assign product = acc_q[PROD_W-1:0];

`ifdef BOOTH_ACC_OVF_CHECK_EN
  logic ovf_q, ovf_d;
  logic hi_all_ones, hi_all_zeros;

  // Result fits PROD_W signed bits only if the bits above the product sign
  // bit are copies of it.
  assign hi_all_ones  = &acc_sum[PP_W-1:PROD_W-1];
  assign hi_all_zeros = ~|acc_sum[PP_W-1:PROD_W-1];

  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = 1'b0;
    end else if ((state_q == ACCUM) && last_add) begin
      ovf_d = !(hi_all_ones || hi_all_zeros);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  // Upper accumulator bits only feed the overflow check.
  logic unused_acc_hi;
  logic unused_accept;
  assign unused_acc_hi = ^acc_q[PP_W-1:PROD_W];
  assign unused_accept = accept;
  assign ovf           = 1'b0;
`endif

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Purpose: directed self-checking bench for booth_pp_accumulator.
// Latency: checks 6-cycle accept-to-valid and 8-cycle back-to-back period.
// Backpressure: exercises held DONE with pending input and mid-flight reset.
module tb_booth_pp_accumulator;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [33:0] pp [6];
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] product;
  logic               ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

`ifdef BOOTH_ACC_OVF_CHECK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  booth_pp_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp0       (pp[0]),
    .pp1       (pp[1]),
    .pp2       (pp[2]),
    .pp3       (pp[3]),
    .pp4       (pp[4]),
    .pp5       (pp[5]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Radix-8 Booth encoder model used only to build stimulus: digit from
  // bits b[3i+2:3i-1], weight 8^i, sign-extended to 34 bits.
  function automatic logic signed [33:0] booth_pp(input int a, input int b, input int i);
    int     bx, grp, dig;
    longint p;
    bx  = b <<< 1;
    grp = (bx >>> (3 * i)) & 15;
    dig = -4 * ((grp >> 3) & 1) + 2 * ((grp >> 2) & 1) + ((grp >> 1) & 1) + (grp & 1);
    p   = (longint'(a) * dig) <<< (3 * i);
    return 34'(p);
  endfunction

  task automatic set_pps(input int a, input int b);
    for (int i = 0; i < 6; i++) pp[i] = booth_pp(a, b, i);
  endtask

  task automatic scramble_pps();
    for (int i = 0; i < 6; i++) pp[i] = 34'({$urandom(), $urandom()});
  endtask

  // Runs in the "#1 after posedge" phase; returns after the accept edge (+1).
  task automatic wait_accept(output int acc_cyc);
    logic ok;
    ok      = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready && in_valid) begin
        @(posedge clk); #1;
        acc_cyc = cyc;
        ok      = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_val("accept_seen", 32'(ok), 32'd1);
  endtask

  // From the accept point, runs until in_ready returns (out_ready assumed 1).
  task automatic finish_txn(output int lat, output int busy, output logic [31:0] prod,
                            output logic o);
    lat  = -1;
    busy = 0;
    prod = '0;
    o    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) break;
      if (out_valid && lat < 0) begin
        lat  = i;
        prod = product;
        o    = ovf;
      end
      busy++;
      @(posedge clk); #1;
    end
  endtask

  int          ka, kb, kc, lat, busy;
  logic [31:0] prod;
  logic        o;
  int          vld_seen;
  int          unstable;
  int          rdy_seen;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) pp[i] = '0;
    #2;
    check_val("rst_in_ready",  32'(in_ready),  32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_product",   product,        32'd0);
    check_val("rst_ovf",       32'(ovf),       32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic product 1234 * -567
    set_pps(1234, -567); in_valid = 1'b1;
    wait_accept(ka);
    in_valid = 1'b0; scramble_pps();
    finish_txn(lat, busy, prod, o);
    check_val("basic_latency", 32'(lat),  32'd6);
    check_val("basic_busy",    32'(busy), 32'd7);
    check_val("basic_product", prod,      -32'sd699678);
    check_val("basic_ovf",     32'(o),    32'd0);

    // Extreme operands
    set_pps(-32768, -32768); in_valid = 1'b1;
    wait_accept(ka);
    in_valid = 1'b0; scramble_pps();
    finish_txn(lat, busy, prod, o);
    check_val("ext_mm_product", prod,   32'h4000_0000);
    check_val("ext_mm_ovf",     32'(o), 32'd0);

    set_pps(-32768, 32767); in_valid = 1'b1;
    wait_accept(ka);
    in_valid = 1'b0; scramble_pps();
    finish_txn(lat, busy, prod, o);
    check_val("ext_mp_product", prod,   32'hC000_8000);
    check_val("ext_mp_ovf",     32'(o), 32'd0);

    // Backpressure: hold DONE 10 cycles with a new set pending
    out_ready = 1'b0;
    set_pps(300, -25); in_valid = 1'b1;
    wait_accept(ka);
    in_valid = 1'b0; scramble_pps();
    vld_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin vld_seen = 1; break; end
      @(posedge clk); #1;
    end
    check_val("bp_valid_seen", 32'(vld_seen), 32'd1);
    check_val("bp_product",    product,       -32'sd7500);
    set_pps(-1000, 999); in_valid = 1'b1;
    unstable = 0;
    rdy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (product !== -32'sd7500 || !out_valid) unstable++;
      if (in_ready) rdy_seen++;
    end
    check_val("bp_product_stable", 32'(unstable), 32'd0);
    check_val("bp_in_ready_low",   32'(rdy_seen), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;  // consume edge
    check_val("bp_idle_in_ready",  32'(in_ready),  32'd1);
    check_val("bp_idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;  // accept edge, one cycle after consume
    check_val("bp_accept_next", 32'(in_ready), 32'd0);
    in_valid = 1'b0; scramble_pps();
    finish_txn(lat, busy, prod, o);
    check_val("bp_new_latency", 32'(lat), 32'd6);
    check_val("bp_new_product", prod,     -32'sd999000);

    // Back-to-back with out_ready tied high and in_valid held
    set_pps(100, 200); in_valid = 1'b1;
    wait_accept(ka);
    set_pps(-7, 9);
    finish_txn(lat, busy, prod, o);
    check_val("b2b_0_product", prod, 32'd20000);
    wait_accept(kb);
    set_pps(32767, 32767);
    finish_txn(lat, busy, prod, o);
    check_val("b2b_1_product", prod, -32'sd63);
    wait_accept(kc);
    in_valid = 1'b0; scramble_pps();
    finish_txn(lat, busy, prod, o);
    check_val("b2b_2_product", prod,      32'h3FFF_0001);
    check_val("b2b_period_1",  32'(kb - ka), 32'd8);
    check_val("b2b_period_2",  32'(kc - kb), 32'd8);

    // Reset during the third ACCUM cycle
    set_pps(5, 5); in_valid = 1'b1;
    wait_accept(ka);
    in_valid = 1'b0; scramble_pps();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_product",   product,        32'd0);
    check_val("mid_rst_ovf",       32'(ovf),       32'd0);
    @(negedge clk); rst_n = 1'b1;
    vld_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) vld_seen++;
    end
    check_val("mid_rst_no_valid", 32'(vld_seen), 32'd0);

    // Overflow case: 0x7FFFFFFF + 1
    for (int i = 0; i < 6; i++) pp[i] = '0;
    pp[0] = 34'sh0_7FFF_FFFF;
    pp[1] = 34'sd1;
    in_valid = 1'b1;
    wait_accept(ka);
    in_valid = 1'b0; scramble_pps();
    finish_txn(lat, busy, prod, o);
    check_val("ovf_product", prod,   32'h8000_0000);
    check_val("ovf_flag",    32'(o), 32'(OVF_EXP));

    // ovf clears on the next accept
    set_pps(3, -3); in_valid = 1'b1;
    wait_accept(ka);
    check_val("ovf_clear_on_accept", 32'(ovf), 32'd0);
    in_valid = 1'b0; scramble_pps();
    finish_txn(lat, busy, prod, o);
    check_val("post_ovf_product", prod,   -32'sd9);
    check_val("post_ovf_flag",    32'(o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/booth_pp_accumulator.md
# booth_pp_accumulator

Sequential partial-product reducer for the radix-8 Booth multiplier datapath. It sits directly downstream of the Booth encoder. It accepts one set of six pre-shifted, sign-extended 34-bit partial products per transaction over a valid/ready handshake. It accumulates them one per cycle and presents the signed 32-bit product on a valid/ready output until it is consumed.

## Interface
Parameters:
- `NUM_PP`, 6: partial products per transaction; fixed by 16-bit radix-8 encoding.
- `PP_W`, 34: partial-product and accumulator width.
- `PROD_W`, 32: product width; equals the low `PROD_W` bits of the accumulator.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: partial-product set valid.
- `in_ready`, output, 1: block can accept a set.
- `pp0`..`pp5`, input, `PP_W` each, signed: partial products already at their final weights.
- `out_valid`, output, 1: `product` valid.
- `out_ready`, input, 1: downstream accepts `product`.
- `product`, output, `PROD_W`, signed: the product, equal to the sum of `pp0`..`pp5`, truncated.
- `ovf`, output, 1: sign-inconsistency flag. It is meaningful only with the macro described under Configuration.

## Operation
- State machine has three states: IDLE, ACCUM, DONE.
- **IDLE**
  - `in_ready` = 1 and `out_valid` = 0.
  - On `in_valid && in_ready`, all six pp inputs are latched into internal registers.
  - `acc` is cleared to 0 and `cnt` is cleared to 0.
  - Next state is ACCUM.
- **ACCUM**
  - `in_ready` = 0.
  - Each cycle performs `acc <= acc + pp_reg[cnt]` and `cnt <= cnt + 1`.
  - The addition is a `PP_W`-bit two's-complement add and wraps modulo 2^`PP_W`.
  - When `cnt == NUM_PP-1`, the final add is performed, `cnt` wraps to 0, and the next state is DONE.
- **DONE**
  - `out_valid` = 1.
  - `product` = `acc[PROD_W-1:0]`, held stable while `out_ready` = 0.
  - On `out_ready` = 1, the result is consumed and the next state is IDLE.
- Input pp values are sampled only on the accept edge. Input changes after that edge do not affect the result in flight.
- `in_valid` in ACCUM or DONE is ignored and produces no accept. The upstream source holds its data until `in_ready`.
- A DONE-state handshake and a new `in_valid` in the same cycle do not produce an accept in that cycle. The new set is accepted at the earliest one cycle later, in IDLE. This gives a one-cycle bubble between transactions.
- Reset values: state = IDLE, `acc` = 0, `cnt` = 0, pp registers = 0, `in_ready` = 1, `out_valid` = 0, `product` = 0, `ovf` = 0.
- Reset asserted mid-ACCUM or mid-DONE discards the transaction immediately. No partial result is emitted after release.

## Timing
- The accept edge is edge k.
- Edges k+1 through k+6 add `pp0` through `pp5` in order.
- `out_valid` rises after edge k+6, giving a latency of 6 cycles from accept to valid.
- The minimum transaction period is 8 cycles: accept, 6 accumulate cycles, and 1 DONE cycle with `out_ready` = 1. The next accept is at edge k+8.
- All outputs are registered or decoded from state only. No input-to-output combinational paths exist.

## Configuration
- Macro: `BOOTH_ACC_OVF_CHECK_EN`.
- **Defined:** in the final ACCUM cycle, `ovf` is registered as 1 when `acc[PP_W-1:PROD_W-1]` after the final add is not all-equal, i.e. the result does not fit in `PROD_W` signed bits.
  - `ovf` is valid with `out_valid` and holds through DONE.
  - `ovf` clears on the next accept.
  - Legal Booth inputs never set it.
- **Undefined:** the `ovf` port still exists and is tied to 0. No check logic is synthesized.

## Test plan
- **Basic product.** Apply the encoder partial products for A=1234, B=-567 (in_valid for 1 cycle) -> accept on the first edge, `in_ready` low for 7 cycles, `out_valid` 6 cycles after accept, `product` = -699678, `ovf` = 0.
- **Extreme operands.** Apply the partial products for A=-32768, B=-32768 -> `product` = 0x40000000. Then A=-32768, B=32767 -> `product` = 0xC0008000.
- **Backpressure.** Hold `out_ready` = 0 for 10 cycles in DONE while `in_valid` = 1 with new data -> `product` stays stable and `in_ready` stays 0. When `out_ready` rises, the new set is accepted exactly 1 cycle later.
- **Back-to-back.** Apply 3 transactions with `out_ready` tied to 1 -> accepts occur at edges k, k+8, k+16, and each product matches its reference A*B.
- **Reset mid-operation.** Pulse `rst_n` low during the third ACCUM cycle -> outputs return immediately to their reset values, and no `out_valid` pulse occurs for the aborted set.
- **Overflow check (with macro).** Apply `pp0` = 0x0_7FFF_FFFF, `pp1` = 1, others 0 -> `product` = 0x80000000 and `ovf` = 1. Without the macro, `ovf` = 0.
